// File: rtl/seven_seg_scan_ctrl_pkg.sv
// seven_seg_pkg: segment patterns, converter state type and
// small helpers shared by the seven-segment scan controller.
package seven_seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1111110;

    // a..g MSB-first, active-low
    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'b0000001,
        7'b1001111,
        7'b0010010,
        7'b0000110,
        7'b1001100,
        7'b0100100,
        7'b0100000,
        7'b0001111,
        7'b0000000,
        7'b0000100
    };

    typedef enum logic {
        CV_IDLE,
        CV_RUN
    } cv_state_t;

    function automatic logic [SEG_W-1:0] bcd_to_seg(
        input logic [3:0] d
    );
        logic [SEG_W-1:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0: s = SEG_DIGIT[0];
            4'd1: s = SEG_DIGIT[1];
            4'd2: s = SEG_DIGIT[2];
            4'd3: s = SEG_DIGIT[3];
            4'd4: s = SEG_DIGIT[4];
            4'd5: s = SEG_DIGIT[5];
            4'd6: s = SEG_DIGIT[6];
            4'd7: s = SEG_DIGIT[7];
            4'd8: s = SEG_DIGIT[8];
            4'd9: s = SEG_DIGIT[9];
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] add3(
        input logic [3:0] n
    );
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load/busy handshake bundle between application logic and the
// seven-segment scan controller.
interface seven_seg_scan_ctrl_if #(
    parameter int VALUE_W = 14
) ();

    logic [VALUE_W-1:0] value;
    logic               load;
    logic               busy;
    logic               overflow;

    modport master (
        output value,
        output load,
        input  busy,
        input  overflow
    );

    modport slave (
        input  value,
        input  load,
        output busy,
        output overflow
    );

endinterface

// File: rtl/seven_seg_scan_ctrl_bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-cycle double-dabble converter with a
// sticky flag for values that do not fit in NUM_DIGITS digits.
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk_12MHz,
    input  logic                    rst,
    input  logic                    start,
    input  logic [VALUE_W-1:0]      bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W);

    cv_state_t          state;
    logic [VALUE_W-1:0] sh;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   adj;
    logic               acc_ovf;
    logic [CNT_W-1:0]   cnt;

    always_comb begin
        adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            adj[4*i +: 4] = add3(acc[4*i +: 4]);
        end
    end

    // Any bit shifted past the top nibble means value >= 10^NUM_DIGITS
    assign bcd  = {adj[BCD_W-2:0], sh[VALUE_W-1]};
    assign ovf  = acc_ovf | adj[BCD_W-1];
    assign done = (state == CV_RUN) &&
                  (cnt == CNT_W'(VALUE_W - 1));

    always_ff @(posedge clk_12MHz) begin
        if (rst) begin
            state   <= CV_IDLE;
            busy    <= 1'b0;
            sh      <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
            cnt     <= '0;
        end else begin
            unique case (state)
                CV_IDLE: begin
                    if (start) begin
                        state   <= CV_RUN;
                        busy    <= 1'b1;
                        sh      <= bin;
                        acc     <= '0;
                        acc_ovf <= 1'b0;
                        cnt     <= '0;
                    end
                end
                CV_RUN: begin
                    sh      <= sh << 1;
                    acc     <= bcd;
                    acc_ovf <= ovf;
                    cnt     <= cnt + 1'b1;
                    if (done) begin
                        state <= CV_IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: BCD conversion plus multiplexed scan of a
// common-anode display. SEVEN_SEG_LZB_EN enables leading-zero blanking.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int CLK_HZ     = 12_000_000,
    parameter int SCAN_HZ    = 1000
) (
    input  logic                  clk_12MHz,
    input  logic                  rst,
    seven_seg_scan_ctrl_if.slave  ld,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic [SEG_W-1:0]      segments
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BCD_W = 4 * NUM_DIGITS;

    logic             cv_busy;
    logic             cv_done;
    logic [BCD_W-1:0] cv_bcd;
    logic             cv_ovf;

    logic [BCD_W-1:0] disp_bcd;
    logic             disp_ovf;

    logic [PRE_W-1:0] pre;
    logic [IDX_W-1:0] idx;
    logic             tick;

    logic [3:0]            cur;
    logic [NUM_DIGITS-1:0] en_nxt;
    logic [SEG_W-1:0]      seg_nxt;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk_12MHz (clk_12MHz),
        .rst       (rst),
        .start     (ld.load),
        .bin       (ld.value),
        .busy      (cv_busy),
        .done      (cv_done),
        .bcd       (cv_bcd),
        .ovf       (cv_ovf)
    );

    assign ld.busy     = cv_busy;
    assign ld.overflow = disp_ovf;

    // Digits and overflow flag commit together on the final shift
    always_ff @(posedge clk_12MHz) begin
        if (rst) begin
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
        end else if (cv_done) begin
            disp_bcd <= cv_bcd;
            disp_ovf <= cv_ovf;
        end
    end

    assign tick = (pre == PRE_W'(DIV - 1));

    always_ff @(posedge clk_12MHz) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (tick) begin
            pre <= '0;
            if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            pre <= pre + 1'b1;
        end
    end

    assign cur = disp_bcd[4*idx +: 4];

`ifdef SEVEN_SEG_LZB_EN
    logic [NUM_DIGITS-1:0] shown;

    always_comb begin
        logic seen;
        seen  = 1'b0;
        shown = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen     = seen | (disp_bcd[4*i +: 4] != 4'd0) | (i == 0);
            shown[i] = seen;
        end
    end
`endif

    always_comb begin
        en_nxt  = ~(NUM_DIGITS'(1) << idx);
        seg_nxt = disp_ovf ? SEG_DASH : bcd_to_seg(cur);
`ifdef SEVEN_SEG_LZB_EN
        if (!disp_ovf && !shown[idx]) begin
            en_nxt  = '1;
            seg_nxt = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk_12MHz) begin
        if (rst) begin
            digit_en <= '1;
            segments <= SEG_BLANK;
        end else begin
            digit_en <= en_nxt;
            segments <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: cycle-level reference model built
// from decimal arithmetic, randomized loads, inline output checks.
module tb_seven_seg_scan_ctrl;

    localparam int N       = 4;
    localparam int VW      = 14;
    localparam int CLK_HZ  = 100;
    localparam int SCAN_HZ = 25;
    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int LIMIT   = 9999;
    localparam int SCAN    = N * DIV;

    logic         clk_12MHz = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] digit_en;
    logic [6:0]   segments;

    int nchk = 0;
    int nerr = 0;

    logic [6:0] segs [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    seven_seg_scan_ctrl_if #(.VALUE_W(VW)) ld ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS (N),
        .VALUE_W    (VW),
        .CLK_HZ     (CLK_HZ),
        .SCAN_HZ    (SCAN_HZ)
    ) dut (
        .clk_12MHz (clk_12MHz),
        .rst       (rst),
        .ld        (ld),
        .digit_en  (digit_en),
        .segments  (segments)
    );

    always #5 clk_12MHz = ~clk_12MHz;

    // Reference: shown value/digit of the output registers, pending
    // conversion countdown, and the committed display value.
    int m_k, m_left, m_pend, m_disp, m_oval, m_oidx;
    bit m_ovalid;

    always @(posedge clk_12MHz) begin
        if (rst) begin
            m_k = 0; m_left = 0; m_disp = 0;
            m_oval = 0; m_oidx = 0; m_ovalid = 0;
        end else begin
            m_k++;
            m_oval   = m_disp;
            m_oidx   = ((m_k - 1) / DIV) % N;
            m_ovalid = 1;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_disp = m_pend;
            end else if (ld.load) begin
                m_pend = int'(ld.value);
                m_left = VW;
            end
        end
    end

    function automatic bit x_blank();
`ifdef SEVEN_SEG_LZB_EN
        return m_oidx > 0 && m_oval <= LIMIT && m_oval < 10 ** m_oidx;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [N-1:0] x_en();
        if (!m_ovalid || x_blank()) return '1;
        return ~(N'(1) << m_oidx);
    endfunction

    function automatic logic [6:0] x_seg();
        if (!m_ovalid || x_blank()) return 7'b1111111;
        if (m_oval > LIMIT) return 7'b1111110;
        return segs[(m_oval / (10 ** m_oidx)) % 10];
    endfunction

    function automatic logic x_busy();
        return m_left > 0;
    endfunction

    function automatic logic x_ovf();
        return m_disp > LIMIT;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_12MHz);
            nchk++;
            if (digit_en !== 4'b1111 || segments !== 7'b1111111 ||
                ld.busy !== 1'b0 || ld.overflow !== 1'b0) begin
                nerr++;
                $display("FAIL reset_hold: en=%b seg=%b busy=%b ovf=%b want 1111 1111111 0 0",
                         digit_en, segments, ld.busy, ld.overflow);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 2 * SCAN; c++) begin
            @(negedge clk_12MHz);
            nchk++;
            if (digit_en !== x_en() || segments !== x_seg() ||
                ld.busy !== x_busy() || ld.overflow !== x_ovf()) begin
                nerr++;
                $display("FAIL reset_scan c=%0d: en=%b/%b seg=%b/%b busy=%b/%b ovf=%b/%b",
                         c, digit_en, x_en(), segments, x_seg(),
                         ld.busy, x_busy(), ld.overflow, x_ovf());
            end
            if (c == 0 || c == DIV || c == SCAN) begin
                nchk++;
                if (digit_en !== ((c == DIV) ? 4'b1101 : 4'b1110) ||
                    segments !== 7'b0000001) begin
                    nerr++;
                    $display("FAIL reset_index c=%0d: en=%b seg=%b", c, digit_en, segments);
                end
            end
        end
    endtask

    task automatic test_load_1234();
        int busy_cnt;
        busy_cnt = 0;
        ld.value = VW'(1234);
        ld.load  = 1'b1;
        for (int c = 0; c < VW + 3 + SCAN; c++) begin
            @(negedge clk_12MHz);
            ld.load = 1'b0;
            if (ld.busy === 1'b1) busy_cnt++;
            nchk++;
            if (digit_en !== x_en() || segments !== x_seg() ||
                ld.busy !== x_busy() || ld.overflow !== x_ovf()) begin
                nerr++;
                $display("FAIL load_1234 c=%0d: en=%b/%b seg=%b/%b busy=%b/%b ovf=%b/%b",
                         c, digit_en, x_en(), segments, x_seg(),
                         ld.busy, x_busy(), ld.overflow, x_ovf());
            end
            if (m_ovalid && m_oval == 1234 && (m_oidx == 0 || m_oidx == 3)) begin
                nchk++;
                if (segments !== ((m_oidx == 0) ? 7'b1001100 : 7'b1001111)) begin
                    nerr++;
                    $display("FAIL load_1234_digit idx=%0d: seg=%b", m_oidx, segments);
                end
            end
        end
        nchk++;
        if (busy_cnt != VW) begin
            nerr++;
            $display("FAIL busy_len: got %0d cycles want %0d", busy_cnt, VW);
        end
    endtask

    task automatic test_boundary();
        int vals [2] = '{9999, 10000};
        foreach (vals[k]) begin
            ld.value = VW'(vals[k]);
            ld.load  = 1'b1;
            for (int c = 0; c < VW + 3 + SCAN; c++) begin
                @(negedge clk_12MHz);
                ld.load = 1'b0;
                nchk++;
                if (digit_en !== x_en() || segments !== x_seg() ||
                    ld.busy !== x_busy() || ld.overflow !== x_ovf()) begin
                    nerr++;
                    $display("FAIL boundary v=%0d c=%0d: en=%b/%b seg=%b/%b busy=%b/%b ovf=%b/%b",
                             vals[k], c, digit_en, x_en(), segments, x_seg(),
                             ld.busy, x_busy(), ld.overflow, x_ovf());
                end
            end
            nchk++;
            if (ld.overflow !== (vals[k] > LIMIT)) begin
                nerr++;
                $display("FAIL boundary_ovf v=%0d: ovf=%b", vals[k], ld.overflow);
            end
        end
    endtask

    task automatic test_busy_drop();
        ld.value = VW'($urandom_range(100, 9999));
        ld.load  = 1'b1;
        for (int c = 0; c < VW + 3 + SCAN; c++) begin
            @(negedge clk_12MHz);
            ld.load = (c == 4);
            if (c == 4) ld.value = VW'(42);
            nchk++;
            if (digit_en !== x_en() || segments !== x_seg() ||
                ld.busy !== x_busy() || ld.overflow !== x_ovf()) begin
                nerr++;
                $display("FAIL busy_drop c=%0d: en=%b/%b seg=%b/%b busy=%b/%b ovf=%b/%b",
                         c, digit_en, x_en(), segments, x_seg(),
                         ld.busy, x_busy(), ld.overflow, x_ovf());
            end
        end
        ld.value = VW'(42);
        ld.load  = 1'b1;
        for (int c = 0; c < VW + 3 + SCAN; c++) begin
            @(negedge clk_12MHz);
            ld.load = 1'b0;
            nchk++;
            if (digit_en !== x_en() || segments !== x_seg() ||
                ld.busy !== x_busy() || ld.overflow !== x_ovf()) begin
                nerr++;
                $display("FAIL load_42 c=%0d: en=%b/%b seg=%b/%b busy=%b/%b",
                         c, digit_en, x_en(), segments, x_seg(),
                         ld.busy, x_busy());
            end
        end
    endtask

    task automatic test_rst_mid();
        ld.value = VW'(5678);
        ld.load  = 1'b1;
        for (int c = 0; c < VW + 3 + 2 * SCAN; c++) begin
            @(negedge clk_12MHz);
            ld.load = (c == 5);
            rst     = (c == 5);
            if (c == 6) begin
                nchk++;
                if (ld.busy !== 1'b0) begin
                    nerr++;
                    $display("FAIL rst_mid_busy: busy=%b want 0", ld.busy);
                end
            end
            nchk++;
            if (digit_en !== x_en() || segments !== x_seg() ||
                ld.busy !== x_busy() || ld.overflow !== x_ovf()) begin
                nerr++;
                $display("FAIL rst_mid c=%0d: en=%b/%b seg=%b/%b busy=%b/%b ovf=%b/%b",
                         c, digit_en, x_en(), segments, x_seg(),
                         ld.busy, x_busy(), ld.overflow, x_ovf());
            end
        end
    endtask

    task automatic test_zero();
        ld.value = VW'(0);
        ld.load  = 1'b1;
        for (int c = 0; c < VW + 3 + 2 * SCAN; c++) begin
            @(negedge clk_12MHz);
            ld.load = 1'b0;
            nchk++;
            if (digit_en !== x_en() || segments !== x_seg() ||
                ld.busy !== x_busy() || ld.overflow !== x_ovf()) begin
                nerr++;
                $display("FAIL zero c=%0d: en=%b/%b seg=%b/%b busy=%b/%b",
                         c, digit_en, x_en(), segments, x_seg(),
                         ld.busy, x_busy());
            end
`ifdef SEVEN_SEG_LZB_EN
            if (c > VW + 1) begin
                nchk++;
                if (digit_en[3:1] !== 3'b111) begin
                    nerr++;
                    $display("FAIL zero_lzb c=%0d: en=%b", c, digit_en);
                end
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        ld.value = VW'(1111);
        ld.load  = 1'b1;
        for (int c = 0; c < 2 * VW + 6 + SCAN; c++) begin
            @(negedge clk_12MHz);
            if (c == 1) ld.value = VW'(2222);
            if (c == VW + 2) ld.load = 1'b0;
            nchk++;
            if (digit_en !== x_en() || segments !== x_seg() ||
                ld.busy !== x_busy() || ld.overflow !== x_ovf()) begin
                nerr++;
                $display("FAIL back_to_back c=%0d: en=%b/%b seg=%b/%b busy=%b/%b",
                         c, digit_en, x_en(), segments, x_seg(),
                         ld.busy, x_busy());
            end
        end
        nchk++;
        if (m_disp != 2222 || ld.overflow !== 1'b0) begin
            nerr++;
            $display("FAIL back_to_back_final: model=%0d want 2222 ovf=%b", m_disp, ld.overflow);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 3) == 0)
                ld.value = VW'($urandom_range(10000, 16383));
            else
                ld.value = VW'($urandom_range(0, 9999));
            ld.load = 1'b1;
            for (int c = 0; c < VW + 3 + SCAN + int'($urandom_range(0, 7)); c++) begin
                @(negedge clk_12MHz);
                ld.load = (c > 0 && c < VW - 2 && $urandom_range(0, 4) == 0);
                if (ld.load) ld.value = VW'($urandom_range(0, 16383));
                nchk++;
                if (digit_en !== x_en() || segments !== x_seg() ||
                    ld.busy !== x_busy() || ld.overflow !== x_ovf()) begin
                    nerr++;
                    $display("FAIL random r=%0d c=%0d: en=%b/%b seg=%b/%b busy=%b/%b ovf=%b/%b",
                             r, c, digit_en, x_en(), segments, x_seg(),
                             ld.busy, x_busy(), ld.overflow, x_ovf());
                end
            end
        end
    endtask

    initial begin
        ld.load  = 1'b0;
        ld.value = '0;
        test_reset();
        test_load_1234();
        test_boundary();
        test_busy_drop();
        test_rst_mid();
        test_zero();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
